// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - parametrised UART receiver with runtime parity and error flags.
// Define UART_RX_MAJORITY_EN to make each bit decision a 2-of-3 vote over the last three ticks.
module uart_rx_cfg #(
  parameter int DATA_BITS  = 8,
  parameter int STOP_BITS  = 1,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 RX,
  input  logic                 brg_en,
  input  logic                 par_en,
  input  logic                 par_odd,
  input  logic                 clr_rdy,
  output logic                 rdy,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 frame_err,
  output logic                 par_err,
  output logic                 overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] START_MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] BIT_END   = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  state_t               r_state;
  logic                 r_rx_meta;
  logic                 r_rx_s;
  logic                 r_rx_prev;
  logic [TW-1:0]        r_tick_cnt;
  logic [3:0]           r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic                 r_par_en;
  logic                 r_par_odd;
  logic                 r_frame_err;
  logic                 r_par_err;
  logic                 r_done;
  logic                 w_bit;

`ifdef UART_RX_MAJORITY_EN
  // Samples from the two previous ticks; with the current rx_s they form the vote.
  logic [1:0] r_vote;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vote <= 2'b11;
    end else if (brg_en) begin
      r_vote <= {r_vote[0], r_rx_s};
    end
  end

  assign w_bit = (r_vote[1] & r_vote[0]) | (r_vote[1] & r_rx_s) | (r_vote[0] & r_rx_s);
`else
  assign w_bit = r_rx_s;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_meta   <= 1'b1;
      r_rx_s      <= 1'b1;
      r_rx_prev   <= 1'b1;
      r_state     <= S_IDLE;
      r_tick_cnt  <= '0;
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_par_en    <= 1'b0;
      r_par_odd   <= 1'b0;
      r_frame_err <= 1'b0;
      r_par_err   <= 1'b0;
      r_done      <= 1'b0;
      rdy         <= 1'b0;
      rx_data     <= '0;
      frame_err   <= 1'b0;
      par_err     <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      r_rx_meta <= RX;
      r_rx_s    <= r_rx_meta;
      r_rx_prev <= r_rx_s;
      r_done    <= 1'b0;

      // Completion takes priority over an acknowledge arriving in the same cycle.
      if (r_done) begin
        rdy       <= 1'b1;
        rx_data   <= r_shift;
        frame_err <= r_frame_err;
        par_err   <= r_par_err;
        overrun   <= rdy & ~clr_rdy;
      end else if (clr_rdy) begin
        rdy       <= 1'b0;
        frame_err <= 1'b0;
        par_err   <= 1'b0;
        overrun   <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (r_rx_prev && !r_rx_s) begin
            r_state     <= S_START;
            r_tick_cnt  <= '0;
            r_par_en    <= par_en;
            r_par_odd   <= par_odd;
            r_frame_err <= 1'b0;
            r_par_err   <= 1'b0;
          end
        end
        default: begin
          if (brg_en) begin
            r_tick_cnt <= r_tick_cnt + 1'b1;
            case (r_state)
              S_START: begin
                if (r_tick_cnt == START_MID) begin
                  if (w_bit) begin
                    r_state <= S_IDLE;
                  end else begin
                    r_state    <= S_DATA;
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                  end
                end
              end
              S_DATA: begin
                if (r_tick_cnt == BIT_END) begin
                  r_tick_cnt <= '0;
                  r_shift    <= {w_bit, r_shift[DATA_BITS-1:1]};
                  if (r_bit_cnt == LAST_DATA) begin
                    r_bit_cnt <= '0;
                    r_state   <= r_par_en ? S_PARITY : S_STOP;
                  end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
                end
              end
              S_PARITY: begin
                if (r_tick_cnt == BIT_END) begin
                  r_tick_cnt <= '0;
                  r_par_err  <= w_bit ^ (^r_shift) ^ r_par_odd;
                  r_state    <= S_STOP;
                end
              end
              S_STOP: begin
                if (r_tick_cnt == BIT_END) begin
                  r_tick_cnt <= '0;
                  if (!w_bit) begin
                    r_frame_err <= 1'b1;
                  end
                  if (r_bit_cnt == LAST_STOP) begin
                    r_bit_cnt <= '0;
                    r_state   <= S_IDLE;
                    r_done    <= 1'b1;
                  end else begin
                    r_bit_cnt <= r_bit_cnt + 4'd1;
                  end
                end
              end
              default: r_state <= S_IDLE;
            endcase
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// tb/tb_uart_rx_cfg.sv - scoreboard bench for uart_rx_cfg (8N1 tick-per-clk and 7-bit/2-stop half-rate instances).
module tb_uart_rx_cfg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, rx8, rx7, brg8, brg7, par_en, par_odd, clr8, clr7;
  logic       rdy8, fe8, pe8, ov8;
  logic [7:0] data8;
  logic       rdy7, fe7, pe7, ov7;
  logic [6:0] data7;

  uart_rx_cfg u8 (
    .clk(clk), .rst_n(rst_n), .RX(rx8), .brg_en(brg8), .par_en(par_en), .par_odd(par_odd),
    .clr_rdy(clr8), .rdy(rdy8), .rx_data(data8), .frame_err(fe8), .par_err(pe8), .overrun(ov8)
  );

  uart_rx_cfg #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLE(16)) u7 (
    .clk(clk), .rst_n(rst_n), .RX(rx7), .brg_en(brg7), .par_en(par_en), .par_odd(par_odd),
    .clr_rdy(clr7), .rdy(rdy7), .rx_data(data7), .frame_err(fe7), .par_err(pe7), .overrun(ov7)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t_send = 0;
  int t_rdy8 = 0;
  logic [11:0] q8[$];
  logic [11:0] q7[$];

  always @(posedge clk) cyc++;
  always @(negedge clk) brg7 = ~brg7;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [11:0] ent(input bit ov, input bit pe, input bit fe, input logic [8:0] d);
    return {ov, pe, fe, d};
  endfunction

  logic [12:0] snap8, prev8 = '0, snap7, prev7 = '0;
  logic [11:0] exp8, exp7;

  always @(negedge clk) begin
    snap8 = {rdy8, ov8, pe8, fe8, 1'b0, data8};
    if (rdy8 && snap8 != prev8) begin
      if (!prev8[12]) t_rdy8 = cyc;
      if (q8.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame8_unexpected: got %0h expected none", snap8[11:0]);
      end else begin
        exp8 = q8.pop_front();
        chk("frame8", {20'd0, snap8[11:0]}, {20'd0, exp8});
      end
    end
    prev8 = snap8;
  end

  always @(negedge clk) begin
    snap7 = {rdy7, ov7, pe7, fe7, 2'b00, data7};
    if (rdy7 && snap7 != prev7) begin
      if (q7.size() == 0) begin
        total++;
        bad++;
        $display("FAIL frame7_unexpected: got %0h expected none", snap7[11:0]);
      end else begin
        exp7 = q7.pop_front();
        chk("frame7", {20'd0, snap7[11:0]}, {20'd0, exp7});
      end
    end
    prev7 = snap7;
  end

  // Line 0 is u8 (16 clks per bit), line 1 is u7 (ticks every other clk, 32 clks per bit).
  task automatic send(input int sel, input logic [8:0] d, input int nb, input bit use_par,
                      input logic pbit, input logic [1:0] stp, input int nstop,
                      input int gbit, input int clr_k);
    logic [15:0] bits;
    logic        v;
    int          n, cpb, k;
    cpb  = (sel == 0) ? 16 : 32;
    bits = '0;
    n    = 1;
    for (int i = 0; i < nb; i++) begin
      bits[n] = d[i];
      n++;
    end
    if (use_par) begin
      bits[n] = pbit;
      n++;
    end
    for (int i = 0; i < nstop; i++) begin
      bits[n] = stp[i];
      n++;
    end
    if (sel == 0) t_send = cyc;
    k = 0;
    for (int b = 0; b < n; b++) begin
      for (int c = 0; c < cpb; c++) begin
        v = bits[b];
        if (gbit >= 0 && b == gbit + 1 && c == 8) v = 1'b1;
        if (sel == 0) begin
          rx8  = v;
          clr8 = (k == clr_k);
        end else begin
          rx7 = v;
        end
        k++;
        @(negedge clk);
      end
    end
    clr8 = 1'b0;
  endtask

  task automatic idle(input int sel, input int n);
    if (sel == 0) rx8 = 1'b1;
    else rx7 = 1'b1;
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_clr(input int sel);
    if (sel == 0) clr8 = 1'b1;
    else clr7 = 1'b1;
    @(negedge clk);
    clr8 = 1'b0;
    clr7 = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rx8 = 1'b1; rx7 = 1'b1; brg8 = 1'b1; brg7 = 1'b0;
    par_en = 1'b0; par_odd = 1'b0; clr8 = 1'b0; clr7 = 1'b0; rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_rdy8", {31'd0, rdy8}, 0);
    chk("reset_data8", {24'd0, data8}, 0);
    chk("reset_flags8", {29'd0, fe8, pe8, ov8}, 0);
    chk("reset_rdy7", {31'd0, rdy7}, 0);
    chk("reset_data7", {25'd0, data7}, 0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // 8N1 0xA5: rdy 156 clks after the start-bit drive (2 sync + 1 edge + 8 + 9*16 + 1).
    q8.push_back(ent(0, 0, 0, 9'h0A5));
    send(0, 9'h0A5, 8, 0, 1'b0, 2'b11, 1, -1, -1);
    idle(0, 20);
    chk("latency8", t_rdy8 - t_send, 156);
    pulse_clr(0);
    chk("clr_rdy8", {31'd0, rdy8}, 0);

    par_en = 1'b1; par_odd = 1'b1;
    q8.push_back(ent(0, 1, 0, 9'h003));
    send(0, 9'h003, 8, 1, 1'b0, 2'b11, 1, -1, -1);
    idle(0, 20);
    pulse_clr(0);
    q8.push_back(ent(0, 0, 0, 9'h003));
    send(0, 9'h003, 8, 1, 1'b1, 2'b11, 1, -1, -1);
    idle(0, 20);
    pulse_clr(0);
    par_odd = 1'b0;
    q8.push_back(ent(0, 0, 0, 9'h007));
    send(0, 9'h007, 8, 1, 1'b1, 2'b11, 1, -1, -1);
    idle(0, 20);
    pulse_clr(0);
    par_en = 1'b0;

    // Low stop bit, then a 40-bit break: only the following 0x11 may be received.
    q8.push_back(ent(0, 0, 1, 9'h05A));
    send(0, 9'h05A, 8, 0, 1'b0, 2'b00, 1, -1, -1);
    repeat (20) @(negedge clk);
    pulse_clr(0);
    repeat (40 * 16) @(negedge clk);
    chk("break_no_rdy", {31'd0, rdy8}, 0);
    idle(0, 32);
    q8.push_back(ent(0, 0, 0, 9'h011));
    send(0, 9'h011, 8, 0, 1'b0, 2'b11, 1, -1, -1);
    idle(0, 20);
    pulse_clr(0);

    q8.push_back(ent(0, 0, 0, 9'h012));
    send(0, 9'h012, 8, 0, 1'b0, 2'b11, 1, -1, -1);
    idle(0, 16);
    q8.push_back(ent(1, 0, 0, 9'h034));
    send(0, 9'h034, 8, 0, 1'b0, 2'b11, 1, -1, -1);
    idle(0, 20);
    pulse_clr(0);
    chk("ovr_clr_rdy", {31'd0, rdy8}, 0);
    chk("ovr_clr_ovr", {31'd0, ov8}, 0);

    // Acknowledge lands on the completion edge (k=155 drives clr_rdy across edge 156).
    q8.push_back(ent(0, 0, 0, 9'h056));
    send(0, 9'h056, 8, 0, 1'b0, 2'b11, 1, -1, -1);
    idle(0, 16);
    q8.push_back(ent(0, 0, 0, 9'h057));
    send(0, 9'h057, 8, 0, 1'b0, 2'b11, 1, -1, 155);
    idle(0, 8);
    chk("clr_on_done_rdy", {31'd0, rdy8}, 1);
    chk("clr_on_done_ovr", {31'd0, ov8}, 0);
    pulse_clr(0);

    rx8 = 1'b0;
    repeat (4) @(negedge clk);
    rx8 = 1'b1;
    repeat (40) @(negedge clk);
    chk("false_start_rdy", {31'd0, rdy8}, 0);
    q8.push_back(ent(0, 0, 0, 9'h0C3));
    send(0, 9'h0C3, 8, 0, 1'b0, 2'b11, 1, -1, -1);
    idle(0, 20);
    pulse_clr(0);

`ifdef UART_RX_MAJORITY_EN
    q8.push_back(ent(0, 0, 0, 9'h000));
`else
    q8.push_back(ent(0, 0, 0, 9'h008));
`endif
    send(0, 9'h000, 8, 0, 1'b0, 2'b11, 1, 3, -1);
    idle(0, 20);

    q7.push_back(ent(0, 0, 0, 9'h07F));
    send(1, 9'h07F, 7, 0, 1'b0, 2'b11, 2, -1, -1);
    idle(1, 40);
    pulse_clr(1);
    q7.push_back(ent(0, 0, 1, 9'h02A));
    send(1, 9'h02A, 7, 0, 1'b0, 2'b01, 2, -1, -1);
    idle(1, 40);

    rx7 = 1'b0;
    repeat (32 * 4) @(negedge clk);
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_rdy7", {31'd0, rdy7}, 0);
    chk("midrst_data7", {25'd0, data7}, 0);
    chk("midrst_fe7", {31'd0, fe7}, 0);
    chk("midrst_rdy8", {31'd0, rdy8}, 0);
    chk("midrst_data8", {24'd0, data8}, 0);
    rx7 = 1'b1;
    rst_n = 1'b1;
    repeat (400) @(negedge clk);
    chk("midrst_no_rdy7", {31'd0, rdy7}, 0);

    chk("q8_drained", q8.size(), 0);
    chk("q7_drained", q7.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
